// File: rtl/uart_rx_core_pkg.sv
// uart_rx_core_pkg: receiver state encodings and RX FIFO status masks
package uart_rx_core_pkg;
    typedef logic [2:0] rx_state_t;
    localparam rx_state_t RX_STATE_IDLE   = 3'd0;
    localparam rx_state_t RX_STATE_START  = 3'd1;
    localparam rx_state_t RX_STATE_DATA   = 3'd2;
    localparam rx_state_t RX_STATE_PARITY = 3'd3;
    localparam rx_state_t RX_STATE_STOP   = 3'd4;
    localparam logic [3:0] FIFO_EMPTY  = 4'b0001;
    localparam logic [3:0] FIFO_AEMPTY = 4'b0010;
    localparam logic [3:0] FIFO_AFULL  = 4'b0100;
    localparam logic [3:0] FIFO_FULL   = 4'b1000;
endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: RX FIFO write port and error pulses of the receiver
interface uart_rx_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] fwdata;
    logic                  fwrite;
    logic [3:0]            fwstatus;
    logic                  parity_err;
    logic                  frame_err;
    logic                  overrun_err;
    modport master (output fwdata, fwrite, parity_err, frame_err, overrun_err, input fwstatus);
    modport slave  (input fwdata, fwrite, parity_err, frame_err, overrun_err, output fwstatus);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the RX pin, idling high out of reset
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic rx_i,
    output logic rx_s_o
);
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], rx_i};
    end
    assign rx_s_o = sync_q[1];
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver turning start/data/parity/stop frames into FIFO writes
// and one-cycle parity, framing and overrun pulses
module uart_rx_core
    import uart_rx_core_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           RX,
    input  logic           enable_uart,
    uart_rx_core_if.master rxf
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = $clog2(DATA_WIDTH) + 1;
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    // cnt is 0 on the first edge after START entry, so HALF cycles in is cnt == HALF-1
    localparam logic [CW-1:0] CNT_START = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);

    logic                  rx_s;
    rx_state_t             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d, data_q, data_d;
    logic                  par_q, par_d, armed_q, armed_d;
    logic                  wr_q, wr_d, perr_q, perr_d, ferr_q, ferr_d, oerr_q, oerr_d;
    logic                  par_ok, full;

    uart_rx_sync u_sync (.clk(clk), .reset_n(reset_n), .rx_i(RX), .rx_s_o(rx_s));

    assign par_ok = (^shreg_q) == par_q;
    assign full   = |(rxf.fwstatus & FIFO_FULL);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        armed_d = armed_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        oerr_d  = 1'b0;
        if (state_q == RX_STATE_IDLE) begin
            cnt_d = '0;
            // a held-low line must rise before another start is accepted
            if (rx_s) armed_d = 1'b1;
            else if (enable_uart && armed_q) begin
                armed_d = 1'b0;
                state_d = RX_STATE_START;
            end
        end else if (!enable_uart) begin
            state_d = RX_STATE_IDLE;
            cnt_d   = '0;
        end else if (state_q == RX_STATE_START) begin
            if (cnt_q == CNT_START) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s ? RX_STATE_IDLE : RX_STATE_DATA;
            end
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (state_q == RX_STATE_DATA) begin
                shreg_d = {rx_s, shreg_q[DATA_WIDTH-1:1]};
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == IDX_LAST) ? RX_STATE_PARITY : RX_STATE_DATA;
            end else if (state_q == RX_STATE_PARITY) begin
                par_d   = rx_s;
                state_d = RX_STATE_STOP;
            end else begin
                state_d = RX_STATE_IDLE;
                ferr_d  = !rx_s;
                perr_d  = rx_s && !par_ok;
                oerr_d  = rx_s && par_ok && full;
                wr_d    = rx_s && par_ok && !full;
                data_d  = (rx_s && par_ok && !full) ? shreg_q : data_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RX_STATE_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            armed_q <= 1'b1;
            data_q  <= '0;
            wr_q    <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            armed_q <= armed_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
        end
    end

    assign rxf.fwdata      = data_q;
    assign rxf.fwrite      = wr_q;
    assign rxf.parity_err  = perr_q;
    assign rxf.frame_err   = ferr_q;
    assign rxf.overrun_err = oerr_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames against a frame-level model of expected results
module tb_uart_rx_core;
    import uart_rx_core_pkg::*;
    localparam int DW  = 8;
    localparam int CPB = 3;
    localparam int LAT = 3 + (CPB - 1) / 2 + (DW + 2) * CPB;

    typedef struct {
        int          cyc;
        logic [3:0]  k;
        logic [7:0]  d;
    } ev_t;

    logic clk = 1'b0, reset_n = 1'b0, rx = 1'b1, en = 1'b1;
    int cyc = 0, asserts = 0, fails = 0;
    int n_wr = 0, n_perr = 0, n_ferr = 0, n_oerr = 0;
    int s_wr, s_perr, s_ferr, s_oerr, t0;
    ev_t q[$];
    int wr_cyc[$];
    logic [7:0] last = 8'h00;
    logic [3:0] e;

    uart_rx_core_if #(.DATA_WIDTH(DW)) bus ();
    uart_rx_core #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset_n(reset_n), .RX(rx), .enable_uart(en), .rxf(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // model: a frame's outcome follows only from its bits and the full flag,
    // and it appears a fixed LAT edges after the line falls
    task automatic send(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] fr;
        ev_t ev;
        fr = {s, p, d, 1'b0};
        ev.cyc = cyc + LAT;
        ev.d = d;
        ev.k = !s ? 4'b0010 : (p != ^d) ? 4'b0100 : (|(bus.fwstatus & FIFO_FULL)) ? 4'b0001 : 4'b1000;
        q.push_back(ev);
        for (int i = 0; i < 11; i++) begin
            rx = fr[i];
            tick(CPB);
        end
    endtask

    task automatic snap();
        s_wr = n_wr; s_perr = n_perr; s_ferr = n_ferr; s_oerr = n_oerr;
    endtask

    always @(negedge clk) begin
        e = 4'b0000;
        if (!reset_n) last = 8'h00;
        else if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q[0].k;
            if (e[3]) last = q[0].d;
            void'(q.pop_front());
        end
        chk("pulses", {28'd0, bus.fwrite, bus.parity_err, bus.frame_err, bus.overrun_err}, {28'd0, e});
        chk("fwdata", {24'd0, bus.fwdata}, {24'd0, last});
        if (bus.fwrite) begin n_wr++; wr_cyc.push_back(cyc); end
        if (bus.parity_err) n_perr++;
        if (bus.frame_err) n_ferr++;
        if (bus.overrun_err) n_oerr++;
    end

    initial begin
        bus.fwstatus = 4'h0;
        tick(3);
        reset_n = 1'b1;
        tick(3);
        // single good frame with literal timing
        t0 = cyc;
        send(8'hA5, 1'b0, 1'b1);
        chk("a5_early", {31'd0, bus.fwrite}, 32'd0);
        tick(1);
        chk("a5_latency", cyc - t0, 32'd34);
        chk("a5_fwrite", {31'd0, bus.fwrite}, 32'd1);
        chk("a5_data", {24'd0, bus.fwdata}, 32'hA5);
        tick(5);
        // back-to-back frames
        wr_cyc.delete();
        send(8'h01, 1'b1, 1'b1);
        send(8'hFF, 1'b0, 1'b1);
        tick(5);
        chk("b2b_count", wr_cyc.size(), 32'd2);
        chk("b2b_gap", (wr_cyc.size() == 2) ? wr_cyc[1] - wr_cyc[0] : 0, 32'd33);
        chk("b2b_data", {24'd0, bus.fwdata}, 32'hFF);
        // wrong parity then the same word good
        snap();
        send(8'h3C, 1'b1, 1'b1);
        send(8'h3C, 1'b0, 1'b1);
        tick(5);
        chk("par_pulses", n_perr - s_perr, 32'd1);
        chk("par_writes", n_wr - s_wr, 32'd1);
        chk("par_data", {24'd0, bus.fwdata}, 32'h3C);
        // framing error followed by a break
        snap();
        send(8'h55, 1'b0, 1'b0);
        tick(100);
        rx = 1'b1;
        tick(10);
        chk("brk_ferr", n_ferr - s_ferr, 32'd1);
        chk("brk_writes", n_wr - s_wr, 32'd0);
        // overrun, then other status bits set but not full
        snap();
        bus.fwstatus = FIFO_FULL;
        send(8'h77, 1'b0, 1'b1);
        tick(5);
        bus.fwstatus = ~FIFO_FULL;
        send(8'h78, 1'b0, 1'b1);
        tick(5);
        bus.fwstatus = 4'h0;
        chk("ovr_pulses", n_oerr - s_oerr, 32'd1);
        chk("ovr_writes", n_wr - s_wr, 32'd1);
        chk("ovr_data", {24'd0, bus.fwdata}, 32'h78);
        // one-cycle glitch
        snap();
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(40);
        chk("glitch_quiet", (n_wr - s_wr) + (n_perr - s_perr) + (n_ferr - s_ferr) + (n_oerr - s_oerr), 32'd0);
        // enable dropped mid-frame
        rx = 1'b0;
        tick(12);
        en = 1'b0;
        rx = 1'b1;
        tick(10);
        en = 1'b1;
        tick(40);
        chk("abort_quiet", (n_wr - s_wr) + (n_perr - s_perr) + (n_ferr - s_ferr) + (n_oerr - s_oerr), 32'd0);
        // reset mid-frame, then a clean frame
        rx = 1'b0;
        tick(15);
        reset_n = 1'b0;
        rx = 1'b1;
        tick(1);
        chk("rst_fwdata", {24'd0, bus.fwdata}, 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(5);
        send(8'h12, 1'b0, 1'b1);
        tick(5);
        chk("rst_data", {24'd0, bus.fwdata}, 32'h12);
        chk("rst_writes", n_wr - s_wr, 32'd1);
        chk("queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
